watch_time_keeper: RTL and testbench

Calendar/time-of-day core of the watch. It counts seconds from the 1 Hz `clk1sec` strobe, carries through minute, hour, day, month and year with month lengths and leap years, and drives the binary `year..second` buses read by the display and set-mode blocks. It sits directly downstream of the set-mode block: it takes the packed `bin_time` and `en_time` load strobe and overwrites the running time when the load is valid.

---
 rtl/watch_time_keeper.sv | 143 ++++++++++++++
 tb/tb_watch_time_keeper.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/watch_time_keeper.sv
// Calendar/time-of-day core: counts seconds from a synchronized 1 Hz strobe with
// full carry through year, and accepts validated atomic loads from set-mode.
module watch_time_keeper #(
    parameter logic [7:0] RST_YEAR  = 8'd24,
    parameter logic [7:0] RST_MONTH = 8'd1,
    parameter logic [7:0] RST_DAY   = 8'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic [47:0] bin_time,
    input  logic        en_time,
    output logic [7:0]  year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  second,
    output logic        sec_pulse,
    output logic        load_ok,
    output logic        load_err
);

    // Leap rule year[1:0]==0 is exact because 2000 is a leap year.
    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
        logic [7:0] d;
        case (m)
            8'd4, 8'd6, 8'd9, 8'd11: d = 8'd30;
            8'd2:                    d = (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
            default:                 d = 8'd31;
        endcase
        return d;
    endfunction

    logic       sync1_q, sync2_q, edge_q;
    logic       tick;
    logic [7:0] year_q, month_q, day_q, hour_q, min_q, sec_q;
    logic [7:0] year_d, month_d, day_d, hour_d, min_d, sec_d;
    logic       sec_pulse_q, load_ok_q, load_err_q;

    logic [7:0] b_sec, b_min, b_hour, b_day, b_month, b_year;
    logic       load_valid, load_acc;

    assign b_sec   = bin_time[7:0];
    assign b_min   = bin_time[15:8];
    assign b_hour  = bin_time[23:16];
    assign b_day   = bin_time[31:24];
    assign b_month = bin_time[39:32];
    assign b_year  = bin_time[47:40];

    assign load_valid = (b_sec <= 8'd59) && (b_min <= 8'd59) && (b_hour <= 8'd23) &&
                        (b_month >= 8'd1) && (b_month <= 8'd12) && (b_year <= 8'd99) &&
                        (b_day >= 8'd1) && (b_day <= days_in_month(b_month, b_year));
    assign load_acc   = en_time && load_valid;

    assign tick = sync2_q && !edge_q;

    always_comb begin
        year_d  = year_q;
        month_d = month_q;
        day_d   = day_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        // An accepted load swallows a coincident tick; a rejected one does not.
        if (load_acc) begin
            year_d  = b_year;
            month_d = b_month;
            day_d   = b_day;
            hour_d  = b_hour;
            min_d   = b_min;
            sec_d   = b_sec;
        end else if (tick) begin
            if (sec_q == 8'd59) begin
                sec_d = 8'd0;
                if (min_q == 8'd59) begin
                    min_d = 8'd0;
                    if (hour_q == 8'd23) begin
                        hour_d = 8'd0;
                        if (day_q >= days_in_month(month_q, year_q)) begin
                            day_d = 8'd1;
                            if (month_q == 8'd12) begin
                                month_d = 8'd1;
                                year_d  = (year_q == 8'd99) ? 8'd0 : year_q + 8'd1;
                            end else begin
                                month_d = month_q + 8'd1;
                            end
                        end else begin
                            day_d = day_q + 8'd1;
                        end
                    end else begin
                        hour_d = hour_q + 8'd1;
                    end
                end else begin
                    min_d = min_q + 8'd1;
                end
            end else begin
                sec_d = sec_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            edge_q      <= 1'b0;
            year_q      <= RST_YEAR;
            month_q     <= RST_MONTH;
            day_q       <= RST_DAY;
            hour_q      <= 8'd0;
            min_q       <= 8'd0;
            sec_q       <= 8'd0;
            sec_pulse_q <= 1'b0;
            load_ok_q   <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            sync1_q     <= clk1sec;
            sync2_q     <= sync1_q;
            edge_q      <= sync2_q;
            year_q      <= year_d;
            month_q     <= month_d;
            day_q       <= day_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            sec_pulse_q <= tick && !load_acc;
            load_ok_q   <= load_acc;
            load_err_q  <= en_time && !load_valid;
        end
    end

    assign year      = year_q;
    assign month     = month_q;
    assign day       = day_q;
    assign hour      = hour_q;
    assign minute    = min_q;
    assign second    = sec_q;
    assign sec_pulse = sec_pulse_q;
    assign load_ok   = load_ok_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_watch_time_keeper.sv
// Directed bench for watch_time_keeper: carries, leap years, load validation,
// load/tick collisions and asynchronous reset.
module tb_watch_time_keeper;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk1sec = 1'b0;
    logic [47:0] bin_time = '0;
    logic        en_time = 1'b0;
    logic [7:0]  year, month, day, hour, minute, second;
    logic        sec_pulse, load_ok, load_err;

    int n_chk = 0;
    int n_err = 0;
    int n_sp = 0;
    int n_wide = 0;
    logic sp_prev = 1'b0;

    watch_time_keeper dut (
        .clk(clk), .rst(rst), .clk1sec(clk1sec), .bin_time(bin_time), .en_time(en_time),
        .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .second(second),
        .sec_pulse(sec_pulse), .load_ok(load_ok), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Pulse counter sampled on the falling edge; wide counts back-to-back highs.
    always @(negedge clk) begin
        if (sec_pulse) begin
            n_sp = n_sp + 1;
            if (sp_prev) n_wide = n_wide + 1;
        end
        sp_prev = sec_pulse;
    end

    function automatic logic [47:0] tp(input logic [7:0] y, mo, d, h, mi, s);
        return {y, mo, d, h, mi, s};
    endfunction

    function automatic logic [47:0] now();
        return {year, month, day, hour, minute, second};
    endfunction

    task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; second updates on the third rising edge.
    task automatic tick_sec();
        clk1sec = 1'b1;
        repeat (3) @(negedge clk);
        clk1sec = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic load(input string tag, input logic [47:0] v, input logic ok, input logic [47:0] exp_t);
        en_time  = 1'b1;
        bin_time = v;
        @(negedge clk);
        en_time = 1'b0;
        chk({tag, " time"}, now(), exp_t);
        chk({tag, " ok"}, 48'(load_ok), 48'(ok));
        chk({tag, " err"}, 48'(load_err), 48'(!ok));
        @(negedge clk);
        chk({tag, " pulse clr"}, {46'd0, load_ok, load_err}, 48'd0);
    endtask

    initial begin
        int sp0;
        repeat (2) @(negedge clk);
        chk("reset time", now(), tp(24, 1, 1, 0, 0, 0));
        chk("reset pulses", {45'd0, sec_pulse, load_ok, load_err}, 48'd0);
        rst = 1'b1;
        @(negedge clk);

        // Three ticks, first with latency probe
        n_sp = 0; n_wide = 0;
        clk1sec = 1'b1;
        repeat (2) @(negedge clk);
        chk("latency 2 edges", now(), tp(24, 1, 1, 0, 0, 0));
        @(negedge clk);
        chk("latency 3 edges", now(), tp(24, 1, 1, 0, 0, 1));
        clk1sec = 1'b0;
        repeat (3) @(negedge clk);
        tick_sec();
        tick_sec();
        chk("three ticks", now(), tp(24, 1, 1, 0, 0, 3));
        chk("sec_pulse count", 48'(n_sp), 48'd3);
        chk("sec_pulse width", 48'(n_wide), 48'd0);

        // Year rollover
        load("load nye", tp(23, 12, 31, 23, 59, 59), 1'b1, tp(23, 12, 31, 23, 59, 59));
        tick_sec();
        chk("new year", now(), tp(24, 1, 1, 0, 0, 0));

        // Leap and non-leap February
        load("load feb24", tp(24, 2, 28, 23, 59, 59), 1'b1, tp(24, 2, 28, 23, 59, 59));
        tick_sec();
        chk("leap feb29", now(), tp(24, 2, 29, 0, 0, 0));
        load("load feb23", tp(23, 2, 28, 23, 59, 59), 1'b1, tp(23, 2, 28, 23, 59, 59));
        tick_sec();
        chk("nonleap mar1", now(), tp(23, 3, 1, 0, 0, 0));

        // Invalid loads leave time unchanged
        load("bad apr31", tp(24, 4, 31, 1, 2, 3), 1'b0, tp(23, 3, 1, 0, 0, 0));
        load("bad feb29", tp(23, 2, 29, 1, 2, 3), 1'b0, tp(23, 3, 1, 0, 0, 0));
        load("bad hour24", tp(24, 5, 5, 24, 0, 0), 1'b0, tp(23, 3, 1, 0, 0, 0));
        load("bad month0", tp(24, 0, 5, 1, 0, 0), 1'b0, tp(23, 3, 1, 0, 0, 0));
        load("bad year100", tp(100, 1, 1, 0, 0, 0), 1'b0, tp(23, 3, 1, 0, 0, 0));

        // Back-to-back valid loads: last wins
        en_time = 1'b1; bin_time = tp(30, 6, 30, 1, 1, 1);
        @(negedge clk);
        bin_time = tp(31, 7, 31, 2, 2, 2);
        @(negedge clk);
        en_time = 1'b0;
        chk("b2b last", now(), tp(31, 7, 31, 2, 2, 2));

        // Month-end 31 -> next month, and 99 -> 00
        load("load y99", tp(99, 12, 31, 23, 59, 59), 1'b1, tp(99, 12, 31, 23, 59, 59));
        tick_sec();
        chk("century wrap", now(), tp(0, 1, 1, 0, 0, 0));

        // Valid load collides with tick
        sp0 = n_sp;
        clk1sec = 1'b1;
        repeat (2) @(negedge clk);
        en_time = 1'b1; bin_time = tp(24, 5, 5, 10, 0, 0);
        @(negedge clk);
        en_time = 1'b0;
        chk("collide ok time", now(), tp(24, 5, 5, 10, 0, 0));
        chk("collide ok pulse", 48'(load_ok), 48'd1);
        clk1sec = 1'b0;
        repeat (3) @(negedge clk);
        chk("collide no sec_pulse", 48'(n_sp - sp0), 48'd0);

        // Rejected load collides with tick
        sp0 = n_sp;
        clk1sec = 1'b1;
        repeat (2) @(negedge clk);
        en_time = 1'b1; bin_time = tp(24, 5, 5, 24, 0, 0);
        @(negedge clk);
        en_time = 1'b0;
        chk("collide err time", now(), tp(24, 5, 5, 10, 0, 1));
        chk("collide err pulse", 48'(load_err), 48'd1);
        clk1sec = 1'b0;
        repeat (3) @(negedge clk);
        chk("collide sec_pulse", 48'(n_sp - sp0), 48'd1);

        // Asynchronous reset mid-count
        load("load 123456", tp(25, 6, 15, 12, 34, 56), 1'b1, tp(25, 6, 15, 12, 34, 56));
        clk1sec = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async reset time", now(), tp(24, 1, 1, 0, 0, 0));
        chk("async reset pulses", {45'd0, sec_pulse, load_ok, load_err}, 48'd0);
        clk1sec = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post reset idle", now(), tp(24, 1, 1, 0, 0, 0));
        tick_sec();
        chk("post reset tick", now(), tp(24, 1, 1, 0, 0, 1));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
